// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO plus drain sequencer feeding a UART transmitter over a
//            char/write/busy handshake.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_wr_en,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf,
    output logic [7:0]            o_char,
    output logic                  o_write,
    input  logic                  i_busy
);

    localparam int                      c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     c_FULL_COUNT = c_DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]     c_CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0]   c_PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    logic [7:0]             r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_overflow;
    logic [7:0]             r_char;
    logic                   r_write;
    state_t                 r_state;

    logic                   w_wr_accept;
    logic                   w_pop;
    logic [DEPTH_LOG2:0]    w_count_next;

    // Full/empty are registered, so acceptance uses the start-of-cycle view
    assign w_wr_accept = i_wr_en && !r_full;
    assign w_pop       = (r_state == S_IDLE) && !r_empty && !i_busy;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_char     <= 8'h00;
            r_write    <= 1'b0;
            r_state    <= S_IDLE;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_COUNT);
            r_empty <= (w_count_next == '0);

            // A dropped write beats a simultaneous clear
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_write <= 1'b0;
                    if (w_pop) begin
                        r_char  <= r_mem[r_rd_ptr];
                        r_write <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_write <= 1'b0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_write <= 1'b0;
                    if (i_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    r_write <= 1'b0;
                    if (!i_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_char     = r_char;
    assign o_write    = r_write;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo with a serial transmitter and
//            receiver model (4 clocks per bit).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       full, empty, overflow, write;
    logic [4:0] count;
    logic [7:0] chr;
    logic       busy;
    logic       stall = 1'b0;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_data  (wr_data),
        .i_wr_en    (wr_en),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_overflow (overflow),
        .i_clr_ovf  (clr_ovf),
        .o_char     (chr),
        .o_write    (write),
        .i_busy     (busy)
    );

    // Transmitter model: busy rises the cycle after the strobe, 10 bits of 4 clocks
    logic       tx_busy = 1'b0;
    logic       tx_line = 1'b1;
    logic [9:0] tx_sh = 10'h3FF;
    int         tx_bits = 0;
    int         tx_div = 0;

    assign busy = stall | tx_busy;

    always @(posedge clk) begin
        if (!tx_busy) begin
            tx_line <= 1'b1;
            if (write) begin
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, chr, 1'b0};
                tx_bits <= 10;
                tx_div  <= 0;
            end
        end else begin
            tx_line <= tx_sh[0];
            if (tx_div == 3) begin
                tx_div  <= 0;
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_bits <= tx_bits - 1;
                if (tx_bits == 1) tx_busy <= 1'b0;
            end else begin
                tx_div <= tx_div + 1;
            end
        end
    end

    // Serial receiver: sample mid-bit from the start-bit falling edge
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(posedge clk) begin
        if (!rx_act) begin
            if (tx_line == 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
                rx_sh <= {tx_line, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                rx_q.push_back(rx_sh);
                rx_act <= 1'b0;
            end
        end
    end

    // Strobe monitor: every strobe pops the scoreboard
    logic       prev_write = 1'b0;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (write) begin
            strobes++;
            checks++;
            if (prev_write) begin
                errors++;
                $display("FAIL strobe_width actual=2+ cycles required=1 cycle");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual=%02h required=no strobe", chr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (chr !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe_char actual=%02h required=%02h", chr, mon_exp);
                end
            end
        end
        prev_write = write;
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && empty && !busy && !write && !rx_act) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d pending required=0", tag, exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty actual=%b required=1", empty); end
        checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full actual=%b required=0", full); end
        checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count actual=%0d required=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b required=0", overflow); end
        checks++; if (write !== 1'b0)   begin errors++; $display("FAIL reset_write actual=%b required=0", write); end
        checks++; if (chr !== 8'h00)    begin errors++; $display("FAIL reset_char actual=%02h required=00", chr); end
    endtask

    task automatic test_single();
        int s0;
        rx_q.delete();
        s0 = strobes;
        @(negedge clk);
        wr_data = 8'h41; wr_en = 1'b1; exp_q.push_back(8'h41);
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_k1 actual=%0d required=1", count); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL single_write_k1 actual=%b required=0", write); end
        @(negedge clk);
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL single_write_k2 actual=%b required=1", write); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_k2 actual=%0d required=0", count); end
        @(negedge clk);
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL single_write_k3 actual=%b required=0", write); end
        wait_idle("single");
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty actual=%b required=1", empty); end
        checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL single_strobes actual=%0d required=1", strobes - s0); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
            errors++;
            $display("FAIL single_serial actual=%0d bytes required=1 byte 41", rx_q.size());
        end
    endtask

    task automatic test_burst();
        rx_q.delete();
        stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_data = 8'(i); wr_en = 1'b1; exp_q.push_back(8'(i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (full !== 1'b1)   begin errors++; $display("FAIL burst_full actual=%b required=1", full); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL burst_count actual=%0d required=16", count); end
        stall = 1'b0;
        wait_idle("burst");
        checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL burst_rx_len actual=%0d required=16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL burst_rx[%0d] actual=%02h required=%02h", i, rx_q[i], 8'(i)); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf actual=%b required=0", overflow); end
    endtask

    task automatic test_overflow();
        int s0;
        rx_q.delete();
        s0 = strobes;
        stall = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            wr_data = 8'(8'h80 + i); wr_en = 1'b1;
            if (i < 16) exp_q.push_back(8'(8'h80 + i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set actual=%b required=1", overflow); end
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count actual=%0d required=16", count); end
        repeat (5) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b required=1", overflow); end
        clr_ovf = 1'b1; wr_data = 8'hEE; wr_en = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0; wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins actual=%b required=1", overflow); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear actual=%b required=0", overflow); end
        // Release the transmitter and write into the full FIFO in the same cycle as the pop
        stall = 1'b0; wr_data = 8'hDD; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 5'd15)   begin errors++; $display("FAIL fullpop_count actual=%0d required=15", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf actual=%b required=1", overflow); end
        checks++; if (write !== 1'b1)    begin errors++; $display("FAIL fullpop_write actual=%b required=1", write); end
        wait_idle("overflow");
        checks++; if (strobes - s0 != 16) begin errors++; $display("FAIL ovf_strobes actual=%0d required=16", strobes - s0); end
        checks++; if (rx_q.size() != 16)  begin errors++; $display("FAIL ovf_rx_len actual=%0d required=16", rx_q.size()); end
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_still_set actual=%b required=1", overflow); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic test_wrap();
        bit timed_out = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 40; i++) begin
            int n = 0;
            @(negedge clk);
            wr_en = 1'b0;
            while (full && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) timed_out = 1'b1;
            wr_data = 8'(i * 7 + 3); wr_en = 1'b1; exp_q.push_back(8'(i * 7 + 3));
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (timed_out) begin errors++; $display("FAIL wrap_pacing actual=stuck full required=drains"); end
        wait_idle("wrap");
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL wrap_ovf actual=%b required=0", overflow); end
        checks++; if (rx_q.size() != 40) begin errors++; $display("FAIL wrap_rx_len actual=%0d required=40", rx_q.size()); end
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(i * 7 + 3)) begin
                errors++;
                $display("FAIL wrap_rx[%0d] actual=%02h required=%02h", i, rx_q[i], 8'(i * 7 + 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int n = 0;
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_data = 8'(8'h30 + i); wr_en = 1'b1; exp_q.push_back(8'(8'h30 + i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_count_pre actual=%0d required=5", count); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL mid_busy_pre actual=%b required=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) void'(exp_q.pop_back());
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count_post actual=%0d required=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty_post actual=%b required=1", empty); end
        s0 = strobes;
        wr_data = 8'hA5; wr_en = 1'b1; exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL mid_count_new actual=%0d required=1", count); end
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (strobes != s0) begin errors++; $display("FAIL mid_no_strobe actual=%0d strobes required=0", strobes - s0); end
        wait_idle("reset_mid");
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h30 || rx_q[1] !== 8'hA5) begin
            errors++;
            $display("FAIL mid_serial actual=%0d bytes required=2 bytes 30 A5", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
